conv1d_agu: RTL and testbench

Parametrised address generator and sequencer for the multi-kernel 1-D convolution datapath. For each output position it drives a clear strobe, then KERNEL_SIZE tap cycles of weight and input addresses with an accumulate strobe, then per-kernel output addresses and write strobes to the MAC array and output buffer. It adds start/done handshaking, a stall input and an asynchronous reset, and generalises kernel count and stride.

---
 rtl/conv1d_pkg.sv | 38 +++
 rtl/agu_wrap_counter.sv | 37 +++
 rtl/conv1d_agu.sv | 169 ++++++++++++++++
 tb/tb_conv1d_agu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv1d_pkg
//  Description : Shared definitions for the 1-D convolution datapath: the
//                sequencer state encoding and the parameter helper functions
//                used by the address generator, MAC array and buffers.
//  Revision    : 1.0  initial release
// ============================================================================
package conv1d_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_TAP   = 3'd2,
    ST_STORE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Ceiling log2, never less than 1 so every derived bus has at least one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Number of output positions; trailing inputs that cannot fill a window
  // are dropped.
  function automatic int out_size(input int input_size, input int kernel_size,
                                  input int stride);
    return (input_size - kernel_size) / stride + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/agu_wrap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : agu_wrap_counter
//  Description : Counter running 0..MAX and wrapping back to 0. Clear has
//                priority over enable. wrap flags that count sits at MAX.
//  Ports       : clk, rst    - clock, asynchronous active-high reset
//                en          - advance the count
//                clr         - synchronous return to 0
//                count, wrap - current value, count == MAX
//  Revision    : 1.0  initial release
// ============================================================================
module agu_wrap_counter #(
  parameter int MAX   = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = (count == WIDTH'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv1d_agu.sv
`default_nettype none
// ============================================================================
//  Module      : conv1d_agu
//  Description : Address generator / sequencer for the multi-kernel 1-D
//                convolution. Per output position: one clear cycle,
//                KERNEL_SIZE accumulate cycles with weight/input addresses,
//                one valid cycle and one write cycle with output addresses.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                start, en       - begin a pass (IDLE only), advance enable
//                busy, done      - pass in progress, end-of-pass pulse
//                w_addr, x_addr  - per-kernel weight and shared input address
//                out_addr        - per-kernel output address
//                clear, acc,     - accumulator clear, accumulate,
//                valid, write      result valid, output buffer write
//  Revision    : 1.0  initial release
// ============================================================================
module conv1d_agu
  import conv1d_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int KERNELS     = 4,
  parameter int STRIDE      = 1,
  parameter int INPUT_SIZE  = 27,
  localparam int OUT_SIZE   = out_size(INPUT_SIZE, KERNEL_SIZE, STRIDE),
  localparam int W_BITS     = clog2_min1(KERNELS * KERNEL_SIZE),
  localparam int X_BITS     = clog2_min1(INPUT_SIZE),
  localparam int O_BITS     = clog2_min1(KERNELS * OUT_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      en,
  output logic                      busy,
  output logic                      done,
  output logic [KERNELS*W_BITS-1:0] w_addr,
  output logic [X_BITS-1:0]         x_addr,
  output logic [KERNELS*O_BITS-1:0] out_addr,
  output logic                      clear,
  output logic                      acc,
  output logic                      valid,
  output logic                      write
);

  localparam int TAP_BITS = clog2_min1(KERNEL_SIZE);
  localparam int POS_BITS = clog2_min1(OUT_SIZE);

  state_t state, state_next;

  logic [TAP_BITS-1:0] tap, tap_sel;
  logic [POS_BITS-1:0] pos;
  logic                tap_wrap, pos_wrap;
  logic                tap_inc, tap_clr, pos_inc, pos_clr;
  logic                load_x, load_o;

  logic [KERNELS*W_BITS-1:0] w_next;
  logic [KERNELS*O_BITS-1:0] o_next;
  logic [X_BITS-1:0]         x_next;

  agu_wrap_counter #(.MAX(KERNEL_SIZE - 1), .WIDTH(TAP_BITS)) u_tap_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (tap_inc),
    .clr   (tap_clr),
    .count (tap),
    .wrap  (tap_wrap)
  );

  agu_wrap_counter #(.MAX(OUT_SIZE - 1), .WIDTH(POS_BITS)) u_pos_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pos_inc),
    .clr   (pos_clr),
    .count (pos),
    .wrap  (pos_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Every non-IDLE/DONE transition is gated by en so a stall freezes the
  // whole sequencer. tap_sel is the tap index that will be current after
  // the edge, so addresses are loaded in step with entry to the tap cycle.
  always_comb begin
    state_next = state;
    tap_inc    = 1'b0;
    tap_clr    = 1'b0;
    pos_inc    = 1'b0;
    pos_clr    = 1'b0;
    load_x     = 1'b0;
    load_o     = 1'b0;
    tap_sel    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CLEAR;
          pos_clr    = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (en) begin
          state_next = ST_TAP;
          tap_clr    = 1'b1;
          load_x     = 1'b1;
        end
      end
      ST_TAP: begin
        if (en) begin
          if (tap_wrap) begin
            state_next = ST_STORE;
            load_o     = 1'b1;
          end else begin
            tap_inc = 1'b1;
            load_x  = 1'b1;
            tap_sel = tap + 1'b1;
          end
        end
      end
      ST_STORE: begin
        if (en) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (en) begin
          if (pos_wrap) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_CLEAR;
            pos_inc    = 1'b1;
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Strobes are decoded from state and masked by en, so a stalled cycle
  // emits nothing and the strobe reappears once en returns.
  assign busy  = (state != ST_IDLE) && (state != ST_DONE);
  assign done  = (state == ST_DONE);
  assign clear = (state == ST_CLEAR) && en;
  assign acc   = (state == ST_TAP)   && en;
  assign valid = (state == ST_STORE) && en;
  assign write = (state == ST_WRITE) && en;

  assign x_next = X_BITS'(int'(pos) * STRIDE + int'(tap_sel));

  for (genvar k = 0; k < KERNELS; k++) begin : g_kernel
    assign w_next[k*W_BITS +: W_BITS] = W_BITS'(k * KERNEL_SIZE + int'(tap_sel));
    assign o_next[k*O_BITS +: O_BITS] = O_BITS'(k * OUT_SIZE + int'(pos));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr   <= '0;
      x_addr   <= '0;
      out_addr <= '0;
    end else begin
      if (load_x) begin
        w_addr <= w_next;
        x_addr <= x_next;
      end
      if (load_o) out_addr <= o_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv1d_agu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv1d_agu
//  Description : Testbench for conv1d_agu. Three instances: default
//                parameters, a strided two-kernel variant and a minimal
//                single-tap variant. An expected strobe/address stream is
//                queued per pass and popped as the DUT strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv1d_agu;

  typedef struct packed {
    logic [4:0]  kind;   // {done, write, valid, acc, clear}
    logic [63:0] x;
    logic [63:0] w;
    logic [63:0] o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst_b, start0, start_b, en0, en_b;

  logic        busy0, done0, clear0, acc0, valid0, write0;
  logic [15:0] w0;
  logic [4:0]  x0;
  logic [27:0] o0;

  logic        busy1, done1, clear1, acc1, valid1, write1;
  logic [5:0]  w1;
  logic [2:0]  x1;
  logic [5:0]  o1;

  logic        busy2, done2, clear2, acc2, valid2, write2;
  logic [0:0]  w2;
  logic [1:0]  x2;
  logic [1:0]  o2;

  conv1d_agu #(.KERNEL_SIZE(3), .KERNELS(4), .STRIDE(1), .INPUT_SIZE(27)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .en(en0), .busy(busy0), .done(done0),
    .w_addr(w0), .x_addr(x0), .out_addr(o0),
    .clear(clear0), .acc(acc0), .valid(valid0), .write(write0)
  );

  conv1d_agu #(.KERNEL_SIZE(3), .KERNELS(2), .STRIDE(2), .INPUT_SIZE(8)) u_dut1 (
    .clk(clk), .rst(rst_b), .start(start_b), .en(en_b), .busy(busy1), .done(done1),
    .w_addr(w1), .x_addr(x1), .out_addr(o1),
    .clear(clear1), .acc(acc1), .valid(valid1), .write(write1)
  );

  conv1d_agu #(.KERNEL_SIZE(1), .KERNELS(1), .STRIDE(1), .INPUT_SIZE(4)) u_dut2 (
    .clk(clk), .rst(rst_b), .start(start_b), .en(en_b), .busy(busy2), .done(done2),
    .w_addr(w2), .x_addr(x2), .out_addr(o2),
    .clear(clear2), .acc(acc2), .valid(valid2), .write(write2)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int busy_cnt[3];
  int done_cnt[3];
  int write_cnt[3];
  int exp_busy[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int clog2b(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push_exp(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int id, output exp_t e);
    case (id)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Reference model: the complete strobe/address stream of one pass.
  task automatic push_pass(input int id, input int K, input int NK, input int S, input int IN);
    int   os, wb, ob;
    exp_t e;
    os = (IN - K) / S + 1;
    wb = clog2b(NK * K);
    ob = clog2b(NK * os);
    for (int p = 0; p < os; p++) begin
      e = '0; e.kind = 5'b00001;
      push_exp(id, e);
      for (int t = 0; t < K; t++) begin
        e = '0; e.kind = 5'b00010;
        e.x = 64'(p * S + t);
        for (int k = 0; k < NK; k++) e.w = e.w | (64'(k * K + t) << (k * wb));
        push_exp(id, e);
      end
      e = '0; e.kind = 5'b00100;
      for (int k = 0; k < NK; k++) e.o = e.o | (64'(k * os + p) << (k * ob));
      push_exp(id, e);
      e.kind = 5'b01000;
      push_exp(id, e);
    end
    e = '0; e.kind = 5'b10000;
    push_exp(id, e);
    exp_busy[id] = os * (K + 3);
  endtask

  task automatic mon(input int id, input logic r, input logic busy, input logic done,
                     input logic write, input logic valid, input logic acc, input logic clear,
                     input logic [63:0] x, input logic [63:0] w, input logic [63:0] o);
    logic [4:0] k;
    exp_t       e;
    if (r) begin
      busy_cnt[id] = 0;
      return;
    end
    k = {done, write, valid, acc, clear};
    if (busy) busy_cnt[id]++;
    if (k != 5'b0) begin
      if (qsize(id) == 0) begin
        check("unexpected_strobe", 64'(k), 64'd0);
      end else begin
        pop_exp(id, e);
        check("strobe_kind", 64'(k), 64'(e.kind));
        if (e.kind[1]) begin
          check("x_addr", x, e.x);
          check("w_addr", w, e.w);
        end
        if (e.kind[2] || e.kind[3]) check("out_addr", o, e.o);
        if (e.kind[4]) begin
          check("busy_cycles", 64'(busy_cnt[id]), 64'(exp_busy[id]));
          check("busy_at_done", 64'(busy), 64'd0);
          busy_cnt[id] = 0;
        end
      end
      if (done)  done_cnt[id]++;
      if (write) write_cnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0, busy0, done0, write0, valid0, acc0, clear0, 64'(x0), 64'(w0), 64'(o0));
    mon(1, rst_b, busy1, done1, write1, valid1, acc1, clear1, 64'(x1), 64'(w1), 64'(o1));
    mon(2, rst_b, busy2, done2, write2, valid2, acc2, clear2, 64'(x2), 64'(w2), 64'(o2));
  end

  task automatic pulse(input int id);
    @(posedge clk);
    #1;
    if (id == 0) start0 = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    if (id == 0) start0 = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_done(input int id, input int prev, input int budget);
    int n;
    n = 0;
    while (done_cnt[id] == prev && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 64'(done_cnt[id] - prev), 64'd1);
  endtask

  initial begin
    int d0, d1, d2, wc;
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; write_cnt[i] = 0; exp_busy[i] = 0;
    end
    rst0 = 1'b1; rst_b = 1'b1; start0 = 1'b0; start_b = 1'b0; en0 = 1'b1; en_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_0", 64'({busy0, done0, clear0, acc0, valid0, write0, x0, w0, o0}), 64'd0);
    check("reset_outputs_1", 64'({busy1, done1, clear1, acc1, valid1, write1, x1, w1, o1}), 64'd0);
    check("reset_outputs_2", 64'({busy2, done2, clear2, acc2, valid2, write2, x2, w2, o2}), 64'd0);
    rst0 = 1'b0; rst_b = 1'b0;

    // Strided two-kernel and minimal single-tap configurations.
    d1 = done_cnt[1]; d2 = done_cnt[2];
    push_pass(1, 3, 2, 2, 8);
    push_pass(2, 1, 1, 1, 4);
    pulse(1);
    check("busy_after_start_1", 64'(busy1), 64'd1);
    check("clear_after_start_1", 64'(clear1), 64'd1);
    wait_done(1, d1, 100);
    wait_done(2, d2, 100);

    // Default configuration, no stalls.
    d0 = done_cnt[0];
    push_pass(0, 3, 4, 1, 27);
    pulse(0);
    wait_done(0, d0, 400);
    repeat (2) @(posedge clk);

    // Two stall cycles at the second tap of position 0.
    d0 = done_cnt[0];
    push_pass(0, 3, 4, 1, 27);
    exp_busy[0] = 152;
    pulse(0);
    @(posedge clk);
    @(posedge clk);
    #1 en0 = 1'b0;
    @(posedge clk);
    #1;
    check("stall_acc", 64'(acc0), 64'd0);
    check("stall_x_hold", 64'(x0), 64'd1);
    @(posedge clk);
    #1 en0 = 1'b1;
    wait_done(0, d0, 400);
    repeat (2) @(posedge clk);

    // Reset during the second tap of position 7, then a clean restart.
    push_pass(0, 3, 4, 1, 27);
    pulse(0);
    repeat (44) @(posedge clk);
    #1;
    check("pre_reset_x", 64'(x0), 64'd8);
    #1 rst0 = 1'b1;
    #1;
    check("async_reset_outputs", 64'({busy0, done0, clear0, acc0, valid0, write0, x0, w0, o0}), 64'd0);
    q0.delete();
    @(posedge clk);
    #1 rst0 = 1'b0;
    d0 = done_cnt[0];
    push_pass(0, 3, 4, 1, 27);
    pulse(0);
    wait_done(0, d0, 400);
    repeat (2) @(posedge clk);

    // start re-pulsed while busy at position 3 has no effect.
    d0 = done_cnt[0];
    wc = write_cnt[0];
    push_pass(0, 3, 4, 1, 27);
    pulse(0);
    repeat (20) @(posedge clk);
    pulse(0);
    wait_done(0, d0, 400);
    repeat (10) @(posedge clk);
    check("single_done", 64'(done_cnt[0] - d0), 64'd1);
    check("write_count", 64'(write_cnt[0] - wc), 64'd25);
    check("idle_busy", 64'(busy0), 64'd0);

    check("sb_left_0", 64'(q0.size()), 64'd0);
    check("sb_left_1", 64'(q1.size()), 64'd0);
    check("sb_left_2", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
